// File: rtl/mm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_pkg : state encoding, width defaults and width check for mm_core_param
// Rev 1.0
// ----------------------------------------------------------------------------
package mm_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DIM_W     = 8;
  localparam int DEF_MAX_N     = 16;
  localparam int DEF_NUM_CORES = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SETUP = 4'd1,
    S_RD_A  = 4'd2,
    S_WA    = 4'd3,
    S_RD_B  = 4'd4,
    S_WB    = 4'd5,
    S_WR    = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8
  } mm_state_e;

  // The accumulator must hold a full product without losing bits.
  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return acc_w >= 2 * data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_core_param_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_core_param_if : single-port data-memory request/grant bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface mm_core_param_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;

  modport master (output rd, wr, addr, wdata, input gnt, rdata);
  modport slave  (input rd, wr, addr, wdata, output gnt, rdata);
endinterface
`default_nettype wire

// File: rtl/mm_mac_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_mac_unit : unsigned multiply-accumulate register with overflow flag
// Rev 1.0
// ----------------------------------------------------------------------------
module mm_mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              RESET_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(a) * ACC_W'(b);
    end
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign res = acc_q[DATA_W-1:0];
  assign ovf = |acc_q[ACC_W-1:DATA_W];

endmodule
`default_nettype wire

// File: rtl/mm_core_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_core_param : hard-wired C = A*B core computing rows CORE_ID, +NUM_CORES, ...
// Rev 1.0
// ----------------------------------------------------------------------------
module mm_core_param
  import mm_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DIM_W     = DEF_DIM_W,
  parameter int MAX_N     = DEF_MAX_N,
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int CORE_ID   = 0
) (
  input  logic              clk,
  input  logic              RESET_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  mm_core_param_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err
);

  if (!acc_w_ok(DATA_W, ACC_W)) begin : g_acc_w_check
    $error("mm_core_param: ACC_W must be at least 2*DATA_W");
  end

  localparam logic [DIM_W:0]    CORE_I = (DIM_W+1)'(CORE_ID);
  localparam logic [DIM_W:0]    NC_I   = (DIM_W+1)'(NUM_CORES);
  localparam logic [ADDR_W-1:0] CORE_A = ADDR_W'(CORE_ID);
  localparam logic [ADDR_W-1:0] NC_A   = ADDR_W'(NUM_CORES);
  localparam logic [DIM_W-1:0]  MAX_D  = DIM_W'(MAX_N);

  mm_state_e         state_q, state_d;
  logic [DIM_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [DIM_W:0]    i_q, i_d;
  logic [DIM_W-1:0]  j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] c_row_q, c_row_d, stride_q, stride_d;
  logic [DATA_W-1:0] a_reg_q, a_reg_d;
  logic              ovf_q, ovf_d, err_q, err_d;

  logic              mac_clr, mac_en, mac_ovf;
  logic [DATA_W-1:0] mac_res;
  logic [DIM_W-1:0]  j_inc, k_inc;
  logic [DIM_W:0]    i_inc, n_ext;
  logic [ADDR_W-1:0] mem_addr_w;

  assign j_inc = j_q + 1'b1;
  assign k_inc = k_q + 1'b1;
  assign i_inc = i_q + NC_I;
  assign n_ext = {1'b0, n_q};

  mm_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .RESET_n (RESET_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (a_reg_q),
    .b       (mem.rdata),
    .res     (mac_res),
    .ovf     (mac_ovf)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    a_ptr_d  = a_ptr_q;
    b_ptr_d  = b_ptr_q;
    c_row_d  = c_row_q;
    stride_d = stride_q;
    a_reg_d  = a_reg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = n;
          a_base_d = a_base;
          b_base_d = b_base;
          c_base_d = c_base;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (n_q > MAX_D) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (n_q == '0 || CORE_I >= n_ext) begin
          state_d = S_DONE;
        end else begin
          i_d      = CORE_I;
          j_d      = '0;
          k_d      = '0;
          mac_clr  = 1'b1;
          a_row_d  = a_base_q + CORE_A * ADDR_W'(n_q);
          a_ptr_d  = a_base_q + CORE_A * ADDR_W'(n_q);
          b_ptr_d  = b_base_q;
          c_row_d  = c_base_q + CORE_A * ADDR_W'(n_q);
          stride_d = NC_A * ADDR_W'(n_q);
          state_d  = S_RD_A;
        end
      end
      S_RD_A: if (mem.gnt) state_d = S_RD_B == S_RD_B ? S_WA : S_WA;
      S_WA: begin
        a_reg_d = mem.rdata;
        state_d = S_RD_B;
      end
      S_RD_B: if (mem.gnt) state_d = S_WB;
      S_WB: begin
        mac_en  = 1'b1;
        k_d     = k_inc;
        a_ptr_d = a_ptr_q + 1'b1;
        b_ptr_d = b_ptr_q + ADDR_W'(n_q);
        state_d = (k_inc == n_q) ? S_WR : S_RD_A;
      end
      S_WR: begin
        if (mem.gnt) begin
          ovf_d   = ovf_q | mac_ovf;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        mac_clr = 1'b1;
        k_d     = '0;
        // Column pointer of B restarts at the new j; A restarts at its row.
        if (j_inc == n_q) begin
          j_d     = '0;
          i_d     = i_inc;
          a_row_d = a_row_q + stride_q;
          a_ptr_d = a_row_q + stride_q;
          c_row_d = c_row_q + stride_q;
          b_ptr_d = b_base_q;
          state_d = (i_inc >= n_ext) ? S_DONE : S_RD_A;
        end else begin
          j_d     = j_inc;
          a_ptr_d = a_row_q;
          b_ptr_d = b_base_q + ADDR_W'(j_inc);
          state_d = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      c_row_q  <= '0;
      stride_q <= '0;
      a_reg_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      c_row_q  <= c_row_d;
      stride_q <= stride_d;
      a_reg_q  <= a_reg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs decode from state only, so an async reset drops them at once.
  always_comb begin
    mem_addr_w = '0;
    case (state_q)
      S_RD_A:  mem_addr_w = a_ptr_q;
      S_RD_B:  mem_addr_w = b_ptr_q;
      S_WR:    mem_addr_w = c_row_q + ADDR_W'(j_q);
      default: mem_addr_w = '0;
    endcase
  end

  assign mem.rd    = (state_q == S_RD_A) || (state_q == S_RD_B);
  assign mem.wr    = (state_q == S_WR);
  assign mem.addr  = mem_addr_w;
  assign mem.wdata = (state_q == S_WR) ? mac_res : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
`default_nettype wire
